instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Write-side companion to the instruction fetch memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words, first byte into [31:24].
- Issues one-cycle write strobes into instruction memory at consecutive word addresses, from 0 up to a programmed word count.
- Used to program instruction memory at boot or from a host link instead of loading it from a file.

Parameters:
- SIZE, 32, number of instruction words the target memory holds.
- ADDRESS_WIDTH, 6, address bus width is ADDRESS_WIDTH+1 bits, matching the fetch pc bus.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset (rst==0 at a posedge resets).
- start  input  1  one-cycle request to begin a load; sampled in IDLE only.
- num_words  input  ADDRESS_WIDTH+1  number of words to load; sampled with start.
- abort  input  1  cancels an in-progress load.
- byte_valid  input  1  byte_in is valid.
- byte_in  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  memory write strobe, one cycle per word.
- wr_addr  output  ADDRESS_WIDTH+1  word address of the write.
- wr_data  output  32  assembled instruction word.
- busy  output  1  high in COLLECT and WRITE.
- done  output  1  one-cycle pulse when all words are written.
- error  output  1  one-cycle pulse on a rejected start.
- words_written  output  ADDRESS_WIDTH+1  count of words written in the current or last load.

Behaviour:
- Reset (rst==0 at posedge), also mid-load:
  - state IDLE; byte_ready, wr_en, busy, done, error = 0; wr_addr, wr_data, words_written = 0.
  - byte counter and assembly register cleared; no write is issued for a partial word.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - start with num_words==0 -> DONE; done pulses the next cycle.
  - start with num_words>SIZE -> error=1 for one cycle; stay IDLE; no other output changes.
  - start with a valid num_words -> latch num_words; clear words_written and wr_addr; go to COLLECT. busy=1 and byte_ready=1 from the next cycle.
  - byte_valid in IDLE is ignored; byte_ready=0.
- COLLECT:
  - A byte is accepted on a cycle with byte_valid && byte_ready.
  - Accepted bytes 0..3 fill [31:24], [23:16], [15:8], [7:0] in that order.
  - byte_valid low means no change; the handshake may stall any number of cycles.
  - On the 4th accept -> WRITE; byte_ready drops the next cycle.
- WRITE (exactly one cycle):
  - wr_en=1, wr_addr=word index, wr_data=assembled word.
  - Next cycle: wr_en=0; wr_addr and words_written increment by 1.
  - If words_written now equals num_words -> DONE; else -> COLLECT with byte_ready=1.
- Latency:
  - 4th byte accepted at edge N -> wr_en high in cycle N+1.
  - byte_ready high again in cycle N+2; at most one byte per cycle otherwise.
- DONE: done=1 for one cycle; busy=0; byte_ready=0; -> IDLE. wr_addr and wr_data hold their last values.
- start while busy is ignored; num_words is not re-sampled.
- abort:
  - In COLLECT, abort -> IDLE next cycle. The partial word is discarded, no wr_en, no done; words_written keeps the count of words already written.
  - abort together with a byte handshake: abort wins; the byte counts as consumed and is discarded.
  - abort during WRITE: the write still completes, then -> IDLE without done.
  - abort in IDLE or DONE has no effect.
- Address never exceeds SIZE-1: this follows from the num_words<=SIZE check. No wrap-around.

Test Plan:
- Reset then start, num_words=2; stream 0x00,0x00,0x00,0x13,0xDE,0xAD,0xBE,0xEF with byte_valid held high -> wr_en at addr 0 data 0x00000013, then at addr 1 data 0xDEADBEEF. done pulses once; words_written=2; byte_ready low after.
- Same load with byte_valid toggling 1/0 every cycle -> identical writes; each wr_en exactly one cycle after the 4th accepted byte.
- start with num_words=SIZE+1 (33) -> error one-cycle pulse, busy stays 0, no wr_en. start with num_words=0 -> done pulse, no wr_en.
- num_words=32 full load -> 32 writes, addresses 0..31 ascending; done after the write to addr 31.
- num_words=3; abort after 6 bytes (one word written) -> one wr_en only, IDLE, words_written=1, no done. A new start then succeeds from addr 0.
- rst=0 asserted mid-word (2 bytes in) -> all outputs 0 next cycle; no write. start after release loads correctly from addr 0.

Source files
------------

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: assembles a big-endian byte stream into 32-bit
// instruction words and writes them to consecutive instruction memory
// addresses, starting at word 0, for a programmed number of words.
module instr_mem_loader #(
    parameter int SIZE          = 32,
    parameter int ADDRESS_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH:0]   num_words,
    input  logic                     abort,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_in,
    output logic                     byte_ready,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH:0]   wr_addr,
    output logic [31:0]              wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [ADDRESS_WIDTH:0]   words_written
);

    localparam int            AW     = ADDRESS_WIDTH + 1;
    localparam logic [AW-1:0] ZERO_W = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_W  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] SIZE_W = AW'(SIZE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [31:0]   asm_q, asm_d;
    logic [AW-1:0] target_q, target_d;
    logic          byte_ready_q, byte_ready_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [AW-1:0] words_written_q, words_written_d;
    logic          byte_acc_s;

    // A byte is consumed only when the loader advertises ready.
    assign byte_acc_s = byte_valid & byte_ready_q;

    // Next-state and next-output logic; outputs are decoded from the next
    // state so that every output leaves a flop.
    always_comb begin
        state_d         = state_q;
        byte_cnt_d      = byte_cnt_q;
        asm_d           = asm_q;
        target_d        = target_q;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        words_written_d = words_written_q;
        error_d         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_words == ZERO_W) begin
                        // Empty load finishes immediately with a done pulse.
                        words_written_d = ZERO_W;
                        wr_addr_d       = ZERO_W;
                        state_d         = S_DONE;
                    end else if (num_words > SIZE_W) begin
                        // Would run past the end of memory: reject.
                        error_d = 1'b1;
                    end else begin
                        target_d        = num_words;
                        words_written_d = ZERO_W;
                        wr_addr_d       = ZERO_W;
                        byte_cnt_d      = 2'd0;
                        asm_d           = 32'h0000_0000;
                        state_d         = S_COLLECT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (abort) begin
                    // Partial word (and any byte arriving now) is dropped.
                    byte_cnt_d = 2'd0;
                    asm_d      = 32'h0000_0000;
                    state_d    = S_IDLE;
                end else if (byte_acc_s) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: asm_d[31:24] = byte_in;
                        2'd1: asm_d[23:16] = byte_in;
                        2'd2: asm_d[15:8]  = byte_in;
                        2'd3: begin
                            wr_data_d = {asm_q[31:8], byte_in};
                            asm_d     = 32'h0000_0000;
                            state_d   = S_WRITE;
                        end
                        default: begin
                            byte_cnt_d = 2'd0;
                            asm_d      = 32'h0000_0000;
                        end
                    endcase
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_WRITE: begin
                // The write always completes, even when aborted.
                wr_addr_d       = wr_addr_q + ONE_W;
                words_written_d = words_written_q + ONE_W;
                if (abort) begin
                    state_d = S_IDLE;
                end else if ((words_written_q + ONE_W) == target_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        byte_ready_d = (state_d == S_COLLECT);
        wr_en_d      = (state_d == S_WRITE);
        busy_d       = (state_d == S_COLLECT) || (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            byte_cnt_q      <= 2'd0;
            asm_q           <= 32'h0000_0000;
            target_q        <= ZERO_W;
            byte_ready_q    <= 1'b0;
            wr_en_q         <= 1'b0;
            wr_addr_q       <= ZERO_W;
            wr_data_q       <= 32'h0000_0000;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            words_written_q <= ZERO_W;
        end else begin
            state_q         <= state_d;
            byte_cnt_q      <= byte_cnt_d;
            asm_q           <= asm_d;
            target_q        <= target_d;
            byte_ready_q    <= byte_ready_d;
            wr_en_q         <= wr_en_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
            words_written_q <= words_written_d;
        end
    end

    assign byte_ready    = byte_ready_q;
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = words_written_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader: transaction-level reference model,
// per-cycle output comparison, directed scenarios plus random traffic.
module tb_instr_mem_loader;

    localparam int SIZE = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  num_words = 7'd0;
    logic        abort = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_ready;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [6:0]  words_written;

    always #5 clk = ~clk;

    instr_mem_loader #(.SIZE(32), .ADDRESS_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words),
        .abort(abort), .byte_valid(byte_valid), .byte_in(byte_in),
        .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .error(error),
        .words_written(words_written)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a load is "active" while words remain; the current
    // word is a byte queue, a full queue becomes one write on the next cycle.
    bit          m_loading, m_writing, m_finishing, m_accepted;
    int          m_target, m_written, m_addr;
    logic [7:0]  m_word[$];
    logic        e_ready, e_wr_en, e_busy, e_done, e_err;
    logic [31:0] e_data;

    logic [38:0] wlog[$];
    int          done_cnt;
    logic [7:0]  stream[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one clock edge using the inputs present now.
    task automatic model_step();
        m_accepted = 1'b0;
        if (!rst) begin
            m_loading = 0; m_writing = 0; m_finishing = 0;
            m_written = 0; m_addr = 0; m_word.delete();
            e_data = 32'd0; e_wr_en = 0; e_done = 0; e_err = 0;
        end else begin
            e_wr_en = 0; e_done = 0; e_err = 0;
            if (m_finishing) begin
                m_finishing = 0;
            end else if (!m_loading) begin
                if (start) begin
                    if (num_words == 7'd0) begin
                        m_written = 0; m_addr = 0;
                        m_finishing = 1; e_done = 1;
                    end else if (int'(num_words) > SIZE) begin
                        e_err = 1;
                    end else begin
                        m_target = int'(num_words);
                        m_written = 0; m_addr = 0; m_word.delete();
                        m_loading = 1;
                    end
                end
            end else if (m_writing) begin
                m_writing = 0;
                m_written++; m_addr++;
                if (abort) m_loading = 0;
                else if (m_written == m_target) begin
                    m_loading = 0; m_finishing = 1; e_done = 1;
                end
            end else begin
                m_accepted = byte_valid;
                if (abort) begin
                    m_word.delete(); m_loading = 0;
                end else if (byte_valid) begin
                    m_word.push_back(byte_in);
                    if (m_word.size() == 4) begin
                        e_data = {m_word[0], m_word[1], m_word[2], m_word[3]};
                        e_wr_en = 1; m_writing = 1; m_word.delete();
                    end
                end
            end
        end
        e_busy  = m_loading;
        e_ready = m_loading && !m_writing;
    endtask

    task automatic compare();
        check("byte_ready", 64'(byte_ready), 64'(e_ready));
        check("wr_en", 64'(wr_en), 64'(e_wr_en));
        check("wr_addr", 64'(wr_addr), 64'(m_addr));
        check("wr_data", 64'(wr_data), 64'(e_data));
        check("busy", 64'(busy), 64'(e_busy));
        check("done", 64'(done), 64'(e_done));
        check("error", 64'(error), 64'(e_err));
        check("words_written", 64'(words_written), 64'(m_written));
        if (wr_en === 1'b1) wlog.push_back({wr_addr, wr_data});
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    // mode 0: valid held, 1: valid toggles, 2: random valid.
    task automatic run_load(input int nw, input int mode, input int abort_after, input int rst_after);
        int idx = 0;
        int budget = 0;
        bit ph = 1'b1;
        start = 1'b1; num_words = 7'(nw); byte_valid = 1'b0;
        cycle();
        start = 1'b0;
        while (m_loading && budget < 2000) begin
            if (idx == abort_after) begin
                abort = 1'b1; byte_valid = 1'b0; cycle(); abort = 1'b0;
                break;
            end
            if (idx == rst_after) begin
                rst = 1'b0; byte_valid = 1'b0; cycle(); rst = 1'b1;
                break;
            end
            case (mode)
                0: byte_valid = 1'b1;
                1: begin byte_valid = ph; ph = !ph; end
                default: byte_valid = 1'($urandom_range(0, 1));
            endcase
            byte_in = (idx < stream.size()) ? stream[idx] : 8'h00;
            cycle();
            if (m_accepted) idx++;
            budget++;
        end
        byte_valid = 1'b0;
        if (budget >= 2000) check("load_timeout", 64'(budget), 64'(0));
        cycle();
        cycle();
    endtask

    task automatic set_test1_stream();
        stream = '{8'h00, 8'h00, 8'h00, 8'h13, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    endtask

    task automatic rand_stream(input int n);
        stream.delete();
        for (int i = 0; i < n; i++) stream.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        logic [38:0] w0, w1;
        bit ok;

        // Reset
        rst = 1'b0;
        cycle(); cycle();
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_wr_addr", 64'(wr_addr), 64'(0));
        rst = 1'b1;
        cycle();

        // Two words, valid held high
        set_test1_stream(); wlog.delete(); done_cnt = 0;
        run_load(2, 0, -1, -1);
        w0 = (wlog.size() > 0) ? wlog[0] : '1;
        w1 = (wlog.size() > 1) ? wlog[1] : '1;
        check("t1_nwrites", 64'(wlog.size()), 64'(2));
        check("t1_write0", 64'(w0), {25'd0, 7'd0, 32'h0000_0013});
        check("t1_write1", 64'(w1), {25'd0, 7'd1, 32'hDEAD_BEEF});
        check("t1_done_cnt", 64'(done_cnt), 64'(1));
        check("t1_words_written", 64'(words_written), 64'(2));
        check("t1_ready_after", 64'(byte_ready), 64'(0));

        // Same load, valid toggling
        set_test1_stream(); wlog.delete(); done_cnt = 0;
        run_load(2, 1, -1, -1);
        w1 = (wlog.size() > 1) ? wlog[1] : '1;
        check("t2_nwrites", 64'(wlog.size()), 64'(2));
        check("t2_write1", 64'(w1), {25'd0, 7'd1, 32'hDEAD_BEEF});

        // Oversize start is rejected
        wlog.delete();
        start = 1'b1; num_words = 7'd33;
        cycle();
        start = 1'b0;
        check("t3_error_pulse", 64'(error), 64'(1));
        check("t3_busy", 64'(busy), 64'(0));
        cycle();
        check("t3_error_clear", 64'(error), 64'(0));

        // Zero-word start
        start = 1'b1; num_words = 7'd0;
        cycle();
        start = 1'b0;
        check("t4_done_pulse", 64'(done), 64'(1));
        cycle();
        check("t4_done_clear", 64'(done), 64'(0));
        check("t4_nwrites", 64'(wlog.size()), 64'(0));

        // Full memory load with random stalls
        rand_stream(4 * SIZE); wlog.delete(); done_cnt = 0;
        run_load(SIZE, 2, -1, -1);
        check("t5_nwrites", 64'(wlog.size()), 64'(SIZE));
        ok = (wlog.size() == SIZE);
        for (int i = 0; i < wlog.size(); i++) if (int'(wlog[i][38:32]) != i) ok = 0;
        check("t5_addr_ascending", 64'(ok), 64'(1));
        check("t5_done_cnt", 64'(done_cnt), 64'(1));

        // Abort after six bytes of a three-word load
        rand_stream(12); wlog.delete(); done_cnt = 0;
        run_load(3, 0, 6, -1);
        check("t6_nwrites", 64'(wlog.size()), 64'(1));
        check("t6_words_written", 64'(words_written), 64'(1));
        check("t6_done_cnt", 64'(done_cnt), 64'(0));
        check("t6_busy", 64'(busy), 64'(0));
        rand_stream(4); wlog.delete();
        run_load(1, 0, -1, -1);
        w0 = (wlog.size() > 0) ? wlog[0] : '1;
        check("t6_restart_addr", 64'(w0[38:32]), 64'(0));

        // Reset in the middle of a word
        rand_stream(8); wlog.delete();
        run_load(2, 0, -1, 2);
        check("t7_nwrites", 64'(wlog.size()), 64'(0));
        check("t7_busy", 64'(busy), 64'(0));
        check("t7_words_written", 64'(words_written), 64'(0));
        set_test1_stream(); wlog.delete();
        run_load(2, 1, -1, -1);
        w0 = (wlog.size() > 0) ? wlog[0] : '1;
        check("t7_reload_write0", 64'(w0), {25'd0, 7'd0, 32'h0000_0013});

        // Random traffic: starts (some invalid), aborts, stalls, resets
        for (int c = 0; c < 3000; c++) begin
            start      = ($urandom_range(0, 9) == 0);
            num_words  = 7'($urandom_range(0, 34));
            abort      = ($urandom_range(0, 39) == 0);
            byte_valid = 1'($urandom_range(0, 1));
            byte_in    = 8'($urandom_range(0, 255));
            rst        = ($urandom_range(0, 299) != 0);
            cycle();
        end
        start = 1'b0; abort = 1'b0; byte_valid = 1'b0; rst = 1'b1;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
